// File: rtl/jtkunio_rom_pkg.sv
// jtkunio_rom_pkg
//   Shared definitions for the video ROM arbiter: slot indices, the arbiter
//   state encoding, the default SDRAM word offsets of each ROM region, and
//   the debug view of the arbiter exported by the top level.
package jtkunio_rom_pkg;

  localparam logic [1:0] SLOT_CHAR = 2'd0;
  localparam logic [1:0] SLOT_SCR  = 2'd1;
  localparam logic [1:0] SLOT_OBJ  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  localparam logic [21:0] DEF_CHAR_OFFSET = 22'h00000;
  localparam logic [21:0] DEF_SCR_OFFSET  = 22'h04000;
  localparam logic [21:0] DEF_OBJ_OFFSET  = 22'h24000;

  // Arbiter internals made visible for checkers and debug.
  typedef struct packed {
    arb_state_e state;
    logic [1:0] gnt;
    logic [1:0] rr;
    logic [2:0] hit;
  } arb_dbg_t;

  // Next slot index in the 0 -> 1 -> 2 -> 0 ring.
  function automatic logic [1:0] slot_inc(input logic [1:0] s);
    return (s == SLOT_OBJ) ? SLOT_CHAR : s + 2'd1;
  endfunction

endpackage

// File: rtl/jtkunio_rom_slot.sv
// jtkunio_rom_slot
//   One-entry cache for a single ROM requester. Holds the last fetched word
//   and its address; a matching request is served without an SDRAM access.
//   Ports:
//     clk, rst_n    clock, asynchronous active-low reset
//     cs_i, addr_i  requester select and word address
//     fill_i        write strobe from the arbiter (fetch for this slot done)
//     fill_addr_i   address the completed fetch was issued for
//     fill_data_i   word returned by SDRAM
//     hit_o         cached entry matches addr_i
//     pend_o        requester active and missing -> needs a fetch
//     ok_o          requester active and hitting -> data_o is valid
//     data_o        stored word, presented at all times
module jtkunio_rom_slot #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs_i,
  input  logic [AW-1:0] addr_i,
  input  logic          fill_i,
  input  logic [AW-1:0] fill_addr_i,
  input  logic [31:0]   fill_data_i,
  output logic          hit_o,
  output logic          pend_o,
  output logic          ok_o,
  output logic [31:0]   data_o
);

  logic [AW-1:0] last_addr_q, last_addr_d;
  logic          valid_q, valid_d;
  logic [31:0]   data_q, data_d;

  // Combinational compare: ok drops in the same cycle the address moves off
  // the cached entry.
  assign hit_o  = valid_q & (addr_i == last_addr_q);
  assign pend_o = cs_i & ~hit_o;
  assign ok_o   = cs_i & hit_o;
  assign data_o = data_q;

  always_comb begin
    last_addr_d = last_addr_q;
    valid_d     = valid_q;
    data_d      = data_q;
    if (fill_i) begin
      last_addr_d = fill_addr_i;
      valid_d     = 1'b1;
      data_d      = fill_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr_q <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
    end else begin
      last_addr_q <= last_addr_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
    end
  end

endmodule

// File: rtl/jtkunio_rom_arb.sv
// jtkunio_rom_arb
//   Shares one SDRAM read port among the char, scroll and object ROM
//   fetchers. Each fetcher has a one-entry cache (jtkunio_rom_slot); misses
//   are granted round-robin and fetched one at a time.
//   Ports:
//     clk, rst_n                     clock, asynchronous active-low reset
//     char_cs/addr -> char_ok/data   char ROM requester (14-bit address)
//     scr_cs/addr  -> scr_ok/data    scroll ROM requester (17-bit address)
//     obj_cs/addr  -> obj_ok/data    object ROM requester (18-bit address)
//     sdram_req/addr                 read request, held until sdram_ack
//     sdram_ack                      controller accepted the request
//     sdram_dst/din                  read data strobe and word
//     dbg_o                          state, grant, rr pointer and slot hits
//
//   Handshake: sdram_req is a valid signal whose payload sdram_addr is
//   frozen while it is high; the cycle with sdram_req & sdram_ack is the
//   transfer. Afterwards the first sdram_dst carries the data. sdram_dst
//   outside that window is ignored.
module jtkunio_rom_arb
  import jtkunio_rom_pkg::*;
#(
  parameter logic [21:0] CHAR_OFFSET = DEF_CHAR_OFFSET,
  parameter logic [21:0] SCR_OFFSET  = DEF_SCR_OFFSET,
  parameter logic [21:0] OBJ_OFFSET  = DEF_OBJ_OFFSET
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        char_cs,
  input  logic [13:0] char_addr,
  output logic        char_ok,
  output logic [31:0] char_data,
  input  logic        scr_cs,
  input  logic [16:0] scr_addr,
  output logic        scr_ok,
  output logic [31:0] scr_data,
  input  logic        obj_cs,
  input  logic [17:0] obj_addr,
  output logic        obj_ok,
  output logic [31:0] obj_data,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        sdram_dst,
  input  logic [31:0] sdram_din,
  output arb_dbg_t    dbg_o
);

  arb_state_e  state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  rr_q, rr_d;
  logic [21:0] cur_addr_q, cur_addr_d;
  // Raw requester address of the fetch in flight; written into the slot on
  // completion even if the requester has moved on meanwhile.
  logic [17:0] cap_addr_q, cap_addr_d;

  logic [2:0]  hit, pend;
  logic        fill;
  logic [1:0]  c0, c1, c2, sel;
  logic [17:0] sel_addr;
  logic [21:0] sel_off;

  // Cache slots
  jtkunio_rom_slot #(.AW(14)) u_char (
    .clk(clk), .rst_n(rst_n), .cs_i(char_cs), .addr_i(char_addr),
    .fill_i(fill && gnt_q == SLOT_CHAR), .fill_addr_i(cap_addr_q[13:0]),
    .fill_data_i(sdram_din), .hit_o(hit[0]), .pend_o(pend[0]),
    .ok_o(char_ok), .data_o(char_data)
  );

  jtkunio_rom_slot #(.AW(17)) u_scr (
    .clk(clk), .rst_n(rst_n), .cs_i(scr_cs), .addr_i(scr_addr),
    .fill_i(fill && gnt_q == SLOT_SCR), .fill_addr_i(cap_addr_q[16:0]),
    .fill_data_i(sdram_din), .hit_o(hit[1]), .pend_o(pend[1]),
    .ok_o(scr_ok), .data_o(scr_data)
  );

  jtkunio_rom_slot #(.AW(18)) u_obj (
    .clk(clk), .rst_n(rst_n), .cs_i(obj_cs), .addr_i(obj_addr),
    .fill_i(fill && gnt_q == SLOT_OBJ), .fill_addr_i(cap_addr_q),
    .fill_data_i(sdram_din), .hit_o(hit[2]), .pend_o(pend[2]),
    .ok_o(obj_ok), .data_o(obj_data)
  );

  function automatic logic pend_at(input logic [2:0] p, input logic [1:0] s);
    case (s)
      SLOT_CHAR: return p[0];
      SLOT_SCR:  return p[1];
      default:   return p[2];
    endcase
  endfunction

  // Round-robin pick: first pending slot in the order rr, rr+1, rr+2.
  assign c0 = rr_q;
  assign c1 = slot_inc(c0);
  assign c2 = slot_inc(c1);

  always_comb begin
    sel = c2;
    if (pend_at(pend, c0))      sel = c0;
    else if (pend_at(pend, c1)) sel = c1;
  end

  always_comb begin
    sel_addr = obj_addr;
    sel_off  = OBJ_OFFSET;
    case (sel)
      SLOT_CHAR: begin
        sel_addr = {4'b0, char_addr};
        sel_off  = CHAR_OFFSET;
      end
      SLOT_SCR: begin
        sel_addr = {1'b0, scr_addr};
        sel_off  = SCR_OFFSET;
      end
      default: ;
    endcase
  end

  // FSM next state
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    cur_addr_d = cur_addr_q;
    cap_addr_d = cap_addr_q;
    fill       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|pend) begin
          gnt_d      = sel;
          cur_addr_d = sel_off + {4'b0, sel_addr};
          cap_addr_d = sel_addr;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        // A data strobe coinciding with the ack belongs to no fetch yet.
        if (sdram_ack) begin
          rr_d    = slot_inc(gnt_q);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sdram_dst) begin
          fill    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= SLOT_CHAR;
      rr_q       <= SLOT_CHAR;
      cur_addr_q <= '0;
      cap_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
      cur_addr_q <= cur_addr_d;
      cap_addr_q <= cap_addr_d;
    end
  end

  // cur_addr_q only changes in IDLE, so the address is stable under req.
  assign sdram_req  = (state_q == ST_REQ);
  assign sdram_addr = cur_addr_q;

  assign dbg_o.state = state_q;
  assign dbg_o.gnt   = gnt_q;
  assign dbg_o.rr    = rr_q;
  assign dbg_o.hit   = hit;

endmodule

// File: tb/tb_jtkunio_rom_arb.sv
// tb_jtkunio_rom_arb
//   Directed scenarios with literal expectations, then randomized traffic,
//   all compared every cycle against a transaction-level model of the
//   caches and the single outstanding SDRAM read.
module tb_jtkunio_rom_arb;
  import jtkunio_rom_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        char_cs = 0, scr_cs = 0, obj_cs = 0;
  logic [13:0] char_addr = '0;
  logic [16:0] scr_addr = '0;
  logic [17:0] obj_addr = '0;
  logic        char_ok, scr_ok, obj_ok;
  logic [31:0] char_data, scr_data, obj_data;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack = 0, sdram_dst = 0;
  logic [31:0] sdram_din = '0;
  arb_dbg_t    dbg;

  jtkunio_rom_arb dut (
    .clk(clk), .rst_n(rst_n),
    .char_cs(char_cs), .char_addr(char_addr), .char_ok(char_ok), .char_data(char_data),
    .scr_cs(scr_cs), .scr_addr(scr_addr), .scr_ok(scr_ok), .scr_data(scr_data),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_ok(obj_ok), .obj_data(obj_data),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .sdram_dst(sdram_dst), .sdram_din(sdram_din), .dbg_o(dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-slot cache contents plus one transaction record.
  logic        m_valid[3];
  logic [17:0] m_last[3];
  logic [31:0] m_data[3];
  int          m_rr;
  bit          t_active, t_acked;
  int          t_slot;
  logic [21:0] t_addr;
  logic [17:0] t_raw;

  function automatic logic [21:0] off_of(input int s);
    return (s == 0) ? 22'h00000 : (s == 1) ? 22'h04000 : 22'h24000;
  endfunction
  function automatic logic [17:0] raw_of(input int s);
    return (s == 0) ? {4'b0, char_addr} : (s == 1) ? {1'b0, scr_addr} : obj_addr;
  endfunction
  function automatic logic cs_of(input int s);
    return (s == 0) ? char_cs : (s == 1) ? scr_cs : obj_cs;
  endfunction
  function automatic logic ok_of(input int s);
    return (s == 0) ? char_ok : (s == 1) ? scr_ok : obj_ok;
  endfunction
  function automatic logic [31:0] data_of(input int s);
    return (s == 0) ? char_data : (s == 1) ? scr_data : obj_data;
  endfunction
  function automatic logic m_hit(input int s);
    return m_valid[s] && (m_last[s] == raw_of(s));
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 3; s++) begin
      m_valid[s] = 0; m_last[s] = '0; m_data[s] = '0;
    end
    m_rr = 0; t_active = 0; t_acked = 0; t_slot = 0; t_addr = '0; t_raw = '0;
  endtask

  task automatic model_compare();
    string nm[3];
    nm[0] = "char"; nm[1] = "scr"; nm[2] = "obj";
    for (int s = 0; s < 3; s++) begin
      chk({nm[s], "_ok"}, ok_of(s), cs_of(s) && m_hit(s));
      chk({nm[s], "_data"}, data_of(s), m_data[s]);
    end
    chk("sdram_req", sdram_req, t_active && !t_acked);
    if (t_active && !t_acked) chk("sdram_addr", sdram_addr, t_addr);
    if (!rst_n) chk("rst_sdram_addr", sdram_addr, 22'h0);
  endtask

  task automatic model_step();
    if (!t_active) begin
      for (int k = 0; k < 3; k++) begin
        int s;
        s = (m_rr + k) % 3;
        if (!t_active && cs_of(s) && !m_hit(s)) begin
          t_active = 1; t_acked = 0; t_slot = s;
          t_raw = raw_of(s);
          t_addr = off_of(s) + {4'b0, t_raw};
        end
      end
    end else if (!t_acked) begin
      if (sdram_ack) begin
        t_acked = 1;
        m_rr = (t_slot + 1) % 3;
      end
    end else if (sdram_dst) begin
      m_valid[t_slot] = 1;
      m_last[t_slot] = t_raw;
      m_data[t_slot] = sdram_din;
      t_active = 0;
    end
  endtask

  // SDRAM controller driver: manual values or a random-latency responder.
  bit          auto_ctrl = 0;
  bit          man_ack = 0, man_dst = 0;
  logic [31:0] man_din = '0;
  bit          c_seen = 0, c_armed = 0;
  int          c_ack_cnt = 0, c_dst_cnt = 0;

  task automatic ctrl_reset();
    c_seen = 0; c_armed = 0; c_ack_cnt = 0; c_dst_cnt = 0;
    man_ack = 0; man_dst = 0; man_din = '0;
  endtask

  task automatic drive_ctrl();
    if (!auto_ctrl) begin
      sdram_ack = man_ack; sdram_dst = man_dst; sdram_din = man_din;
    end else begin
      sdram_ack = 0; sdram_dst = 0; sdram_din = $urandom;
      if (c_armed) begin
        if (c_dst_cnt == 0) begin sdram_dst = 1; c_armed = 0; end
        else c_dst_cnt--;
      end else if ($urandom_range(0, 19) == 0) sdram_dst = 1;
      if (sdram_req) begin
        if (!c_seen) begin c_seen = 1; c_ack_cnt = $urandom_range(0, 4); end
        if (c_ack_cnt == 0) begin
          sdram_ack = 1; c_seen = 0; c_armed = 1; c_dst_cnt = $urandom_range(0, 3);
        end else c_ack_cnt--;
      end
    end
  endtask

  // Grant order capture
  bit          cap_en = 0;
  bit          prev_req = 0;
  logic [21:0] got_q[$];
  logic [21:0] exp_q[$];

  // Inputs for a cycle are set before begin_cycle; literal checks may sit
  // between begin_cycle and end_cycle (still before the rising edge).
  task automatic begin_cycle();
    drive_ctrl();
    #1;
    if (!rst_n) model_clear();
    model_compare();
    if (rst_n) model_step();
    if (cap_en && sdram_req && !prev_req) got_q.push_back(sdram_addr);
    prev_req = sdram_req;
  endtask

  task automatic end_cycle();
    @(negedge clk);
  endtask

  task automatic one_cycle();
    begin_cycle();
    end_cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    char_cs = 0; scr_cs = 0; obj_cs = 0;
    char_addr = '0; scr_addr = '0; obj_addr = '0;
    ctrl_reset();
    one_cycle();
    one_cycle();
    rst_n = 1;
  endtask

  function automatic logic [17:0] rnd_addr();
    case ($urandom_range(0, 5))
      0: return 18'h0;
      1: return 18'h1;
      2: return 18'h2;
      3: return 18'h3;
      4: return 18'h3FFFF;
      default: return 18'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [17:0] ra;
    model_clear();

    // Reset state
    do_reset();
    chk("rst_state", dbg.state, ST_IDLE);
    chk("rst_rr", dbg.rr, 2'd0);
    chk("rst_req", sdram_req, 1'b0);
    chk("rst_char_data", char_data, 32'h0);

    // 1: single char miss
    char_cs = 1; char_addr = 14'h0010;
    begin_cycle(); chk("t1_req_c0", sdram_req, 1'b0); end_cycle();
    man_ack = 1;
    begin_cycle(); chk("t1_req_c1", sdram_req, 1'b1); chk("t1_addr", sdram_addr, 22'h000010); end_cycle();
    man_ack = 0; man_dst = 1; man_din = 32'hCAFE0001;
    begin_cycle(); chk("t1_ok_c2", char_ok, 1'b0); chk("t1_req_c2", sdram_req, 1'b0); end_cycle();
    man_dst = 0;
    begin_cycle(); chk("t1_ok_c3", char_ok, 1'b1); chk("t1_data", char_data, 32'hCAFE0001); end_cycle();
    chk("model_pin_data", m_data[0], 32'hCAFE0001);

    // 2: hits hold without traffic
    for (int i = 0; i < 20; i++) begin
      begin_cycle(); chk("t2_req", sdram_req, 1'b0); chk("t2_ok", char_ok, 1'b1); end_cycle();
    end

    // 3: three distinct misses, round-robin order
    do_reset();
    auto_ctrl = 1; cap_en = 1; got_q.delete();
    exp_q.delete();
    exp_q.push_back(22'h000010); exp_q.push_back(22'h004001); exp_q.push_back(22'h024002);
    char_cs = 1; char_addr = 14'h0010;
    scr_cs = 1; scr_addr = 17'h1;
    obj_cs = 1; obj_addr = 18'h2;
    for (int i = 0; i < 100 && got_q.size() < 3; i++) one_cycle();
    cap_en = 0;
    chk("t3_grant_count", got_q.size(), 3);
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk("t3_grant_addr", got_q.pop_front(), exp_q.pop_front());
    for (int i = 0; i < 20; i++) one_cycle();
    auto_ctrl = 0;

    // 4: object address moves during WAIT
    do_reset();
    obj_cs = 1; obj_addr = 18'h2;
    one_cycle();
    man_ack = 1;
    begin_cycle(); chk("t4_addr", sdram_addr, 22'h024002); end_cycle();
    man_ack = 0; obj_addr = 18'h3;
    begin_cycle(); chk("t4_ok_wait", obj_ok, 1'b0); end_cycle();
    man_dst = 1; man_din = 32'hD00D0002;
    one_cycle();
    man_dst = 0;
    begin_cycle(); chk("t4_ok_after", obj_ok, 1'b0); chk("t4_data", obj_data, 32'hD00D0002);
    chk("t4_gap", sdram_req, 1'b0); end_cycle();
    obj_addr = 18'h2;
    begin_cycle(); chk("t4_req2", sdram_req, 1'b1); chk("t4_addr2", sdram_addr, 22'h024003);
    chk("t4_cached2", obj_ok, 1'b1); end_cycle();

    // 5: ack delayed, request held steady
    for (int i = 0; i < 7; i++) begin
      begin_cycle(); chk("t5_req", sdram_req, 1'b1); chk("t5_addr", sdram_addr, 22'h024003); end_cycle();
    end
    man_ack = 1;
    begin_cycle(); chk("t5_req_ack", sdram_req, 1'b1); end_cycle();
    man_ack = 0; obj_cs = 0;
    one_cycle();
    man_dst = 1; man_din = 32'hD00D0003;
    one_cycle();
    man_dst = 0;
    for (int i = 0; i < 5; i++) begin
      begin_cycle(); chk("t5_no_req", sdram_req, 1'b0); end_cycle();
    end
    obj_cs = 1; obj_addr = 18'h3;
    begin_cycle(); chk("t5_ok", obj_ok, 1'b1); chk("t5_data", obj_data, 32'hD00D0003); end_cycle();

    // 6: reset during WAIT, stray data afterwards
    do_reset();
    char_cs = 1; char_addr = 14'h0020;
    one_cycle();
    man_ack = 1; one_cycle();
    man_ack = 0; one_cycle();
    rst_n = 0; char_cs = 0;
    begin_cycle(); chk("t6_ok", char_ok, 1'b0); chk("t6_req", sdram_req, 1'b0);
    chk("t6_state", dbg.state, ST_IDLE); end_cycle();
    rst_n = 1; man_dst = 1; man_din = 32'hBAD0BAD0;
    one_cycle();
    man_dst = 0;
    begin_cycle(); chk("t6_data", char_data, 32'h0); chk("t6_req_after", sdram_req, 1'b0); end_cycle();
    char_cs = 1;
    one_cycle();
    begin_cycle(); chk("t6_refetch", sdram_addr, 22'h000020); end_cycle();

    // Randomized traffic
    do_reset();
    auto_ctrl = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) char_cs = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) scr_cs = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) obj_cs = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin ra = rnd_addr(); char_addr = ra[13:0]; end
      if ($urandom_range(0, 3) == 0) begin ra = rnd_addr(); scr_addr = ra[16:0]; end
      if ($urandom_range(0, 3) == 0) obj_addr = rnd_addr();
      one_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtkunio_rom_arb.md
# jtkunio_rom_arb

Shares the single SDRAM read port among the three video ROM fetchers: char, scroll and object. Sits between `jtkunio_video` and the SDRAM controller. Each requester keeps a one-entry cache, so a repeated address gets `ok` without an SDRAM access. New fetches are granted round-robin.

## Interface

Parameters:
- `CHAR_OFFSET`, default 22'h00000: word base of the char ROM in SDRAM.
- `SCR_OFFSET`, default 22'h04000: word base of the scroll ROM.
- `OBJ_OFFSET`, default 22'h24000: word base of the object ROM.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `char_cs`  in  1  char requester active.
- `char_addr`  in  14  char ROM word address.
- `char_ok`  out  1  `char_data` valid for the current `char_addr`.
- `char_data`  out  32  char ROM word.
- `scr_cs`  in  1  scroll requester active.
- `scr_addr`  in  17  scroll ROM word address.
- `scr_ok`  out  1  scroll data valid.
- `scr_data`  out  32  scroll ROM word.
- `obj_cs`  in  1  object requester active.
- `obj_addr`  in  18  object ROM word address.
- `obj_ok`  out  1  object data valid.
- `obj_data`  out  32  object ROM word.
- `sdram_req`  out  1  read request. Held high until acknowledged.
- `sdram_addr`  out  22  word address of the read.
- `sdram_ack`  in  1  controller has accepted the request.
- `sdram_dst`  in  1  `sdram_din` is valid this cycle.
- `sdram_din`  in  32  read data.

## Operation

Slot indices: 0 = char, 1 = scroll, 2 = object.

Per-slot state:
- `last_addr`: slot address width.
- `valid`: one bit.
- `data`: 32 bits.

Per-slot combinational signals:
- `hit_i = valid_i & (addr_i == last_addr_i)`.
- `ok_i = cs_i & hit_i`.
- `data_i` = stored `data` register, presented at all times.
- `pend_i = cs_i & ~hit_i`.

State machine, encoded in 2 bits:
- IDLE
  - If any `pend_i` is set, choose slot `g` as the first pending slot in the order `rr, rr+1, rr+2` (mod 3).
  - Register `g`, and capture `cur_addr = OFFSET_g + zero-extended addr_g` (22-bit add, carry discarded).
  - Go to REQ.
- REQ
  - `sdram_req = 1`, `sdram_addr = cur_addr`.
  - On `sdram_ack`: go to WAIT, set `rr = g+1` (mod 3).
- WAIT
  - `sdram_req = 0`.
  - On `sdram_dst`: write `data_g = sdram_din`, `last_addr_g` = address captured in IDLE, `valid_g = 1`. Go to IDLE.

Boundary rules:
- Requester address changes during REQ or WAIT: the fetch still completes and fills the slot with the captured address. The resulting miss makes the slot pending again in IDLE. `sdram_addr` never changes while `sdram_req` is high.
- `cs_i` drops during a fetch: the fetch completes and fills the cache. `ok_i` stays 0 while `cs_i = 0`.
- `sdram_ack` and `sdram_dst` in the same cycle while in REQ: treat as ack only. Data is taken from the first `sdram_dst` seen in WAIT.
- `sdram_dst` while in IDLE or REQ: ignored.
- All three slots pending: granted in turn, 0 → 1 → 2, starting from `rr`. No slot waits more than two other fetches.

Reset values (with `rst_n` low):
- State IDLE, `rr = 0`, all `valid = 0`.
- `last_addr` and `data` cleared to 0.
- `sdram_req = 0`, `sdram_addr = 0`, all `ok = 0`, all `data` outputs = 0.
- Reset asserted mid-fetch abandons the fetch. A late `sdram_dst` after release arrives in IDLE and is ignored.

## Timing

- `ok_i` falls in the same cycle that `addr_i` changes to a non-cached value (combinational compare).
- Miss latency, counting the address change as cycle 0:
  - IDLE arbitration in cycle 0.
  - `sdram_req` high from cycle 1.
  - With `sdram_ack` in cycle 1 and `sdram_dst` in cycle 2, `ok_i` rises in cycle 3.
  - General case: `ok` rises 1 cycle after `sdram_dst`.
- Hit latency is 0 cycles: `ok` stays high while the address matches the cache.
- At most one SDRAM transaction is outstanding. The minimum gap between consecutive requests is 1 IDLE cycle.

## Structure

- Shared package `jtkunio_rom_pkg` holds:
  - slot index constants `SLOT_CHAR`, `SLOT_SCR`, `SLOT_OBJ`;
  - the state encoding (IDLE = 0, REQ = 1, WAIT = 2);
  - the default offsets.
- One natural sub-module, `jtkunio_rom_slot`, instantiated three times and parameterized by address width. It holds `last_addr`, `valid` and `data`, and produces `hit`, `pend` and `ok`.
- The arbiter, FSM and address mux stay in the top level.

## Test plan

1. Reset, then `char_cs = 1`, `char_addr = 14'h0010`; controller acks in cycle 1 and sends `sdram_dst` with `32'hCAFE0001` in cycle 2. Required: `sdram_addr = 22'h000010`, `char_ok` high in cycle 3, `char_data = CAFE0001`.
2. Same `char_addr` held for 20 cycles after the fill. Required: no further `sdram_req`, `char_ok` stays high.
3. All three `cs` high with distinct misses (`scr_addr = 17'h1`, `obj_addr = 18'h2`). Required: grants in order char, scroll, obj, with `sdram_addr` = 0x000010, 0x004001, 0x024002.
4. `obj_addr` changes from 0x2 to 0x3 during WAIT. Required: the slot fills with 0x2, `obj_ok` stays low, then a new request at `22'h024003` is issued.
5. Controller delays `sdram_ack` 7 cycles. Required: `sdram_req` and `sdram_addr` stay constant throughout; no second request is issued.
6. `rst_n` pulsed low during WAIT, then `sdram_dst` arrives after release. Required: all `ok = 0`, `sdram_req = 0`, and the stray data is ignored.
